// File: rtl/led_cube_frame_assembler.sv
// Parses the UART byte stream into cube frames and mode commands.
// Frames build in a back buffer and are swapped to the front buffer only at a scan boundary.
module led_cube_frame_assembler #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         FRAME_BYTES    = 64,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       frame_boundary,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [3:0] mode,
    output logic [7:0] frame_count,
    output logic [7:0] err_count,
    output logic       busy,
    output logic       swap_pending
);

    localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [5:0] LAST_ADDR = 6'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_PAYLOAD,
        S_CHECK
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   idle_cnt;
    logic [5:0]      addr;
    logic [7:0]      chk_acc;
    logic            front_sel;
    logic            front_valid;
    logic [7:0]      mem [0:127];

    logic            err_inc;
    logic            mode_load;
    logic            frame_start;
    logic            wr_en;
    logic            chk_ok;
    logic            timeout;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // A timeout can only fire on a cycle with no byte, so it never collides with a byte's decode.
    always_comb begin
        state_next  = state;
        err_inc     = 1'b0;
        mode_load   = 1'b0;
        frame_start = 1'b0;
        wr_en       = 1'b0;
        chk_ok      = 1'b0;
        timeout     = 1'b0;
        if (state != S_IDLE && !byte_valid && idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout    = 1'b1;
            err_inc    = 1'b1;
            state_next = S_IDLE;
        end else if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_in == SYNC_BYTE) state_next = S_CMD;
                end
                S_CMD: begin
                    state_next = S_IDLE;
                    if (byte_in == 8'h00) begin
                        if (swap_pending) begin
                            err_inc = 1'b1;
                        end else begin
                            frame_start = 1'b1;
                            state_next  = S_PAYLOAD;
                        end
                    end else if (byte_in[7:4] == 4'h1) begin
                        mode_load = 1'b1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                S_PAYLOAD: begin
                    wr_en = 1'b1;
                    if (addr == LAST_ADDR) state_next = S_CHECK;
                end
                S_CHECK: begin
                    state_next = S_IDLE;
                    if (byte_in == chk_acc) chk_ok  = 1'b1;
                    else                    err_inc = 1'b1;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt     <= '0;
            addr         <= '0;
            chk_acc      <= '0;
            mode         <= '0;
            err_count    <= '0;
            frame_count  <= '0;
            swap_pending <= 1'b0;
            front_sel    <= 1'b0;
            front_valid  <= 1'b0;
        end else begin
            if (state == S_IDLE || byte_valid || timeout) idle_cnt <= '0;
            else                                          idle_cnt <= idle_cnt + 1'b1;

            // The checksum starts from the CMD byte itself, so the frame command seeds it.
            if (frame_start) begin
                addr    <= '0;
                chk_acc <= byte_in;
            end else if (wr_en) begin
                addr    <= addr + 6'd1;
                chk_acc <= chk_acc ^ byte_in;
            end

            if (mode_load) mode <= byte_in[3:0];

            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;

            // Uses the registered pending flag, so an accept on a boundary cycle waits for the next one.
            if (frame_boundary && swap_pending) begin
                front_sel    <= ~front_sel;
                swap_pending <= 1'b0;
                frame_count  <= frame_count + 8'd1;
                front_valid  <= 1'b1;
            end else if (chk_ok) begin
                swap_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem[{~front_sel, addr}] <= byte_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)           rd_data <= '0;
        else if (front_valid) rd_data <= mem[{front_sel, rd_addr}];
        else                  rd_data <= '0;
    end

endmodule

// File: tb/tb_led_cube_frame_assembler.sv
// Randomized self-checking bench for led_cube_frame_assembler against a packet-level reference model.
// All bench activity is aligned to the falling clock edge; the DUT samples on the rising edge.
module tb_led_cube_frame_assembler;

    localparam int T = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_valid = 1'b0;
    logic       frame_boundary = 1'b0;
    logic [5:0] rd_addr = 6'd0;
    logic [7:0] rd_data;
    logic [3:0] mode;
    logic [7:0] frame_count;
    logic [7:0] err_count;
    logic       busy;
    logic       swap_pending;

    int checks = 0;
    int errors = 0;

    led_cube_frame_assembler #(
        .SYNC_BYTE      (8'hA5),
        .FRAME_BYTES    (64),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .byte_in        (byte_in),
        .byte_valid     (byte_valid),
        .frame_boundary (frame_boundary),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .mode           (mode),
        .frame_count    (frame_count),
        .err_count      (err_count),
        .busy           (busy),
        .swap_pending   (swap_pending)
    );

    always #5 clk = ~clk;

    // Reference model: the packet in flight is kept as a plain byte queue.
    logic [7:0] pkt [$];
    logic [7:0] m_front [64];
    logic [7:0] m_back [64];
    logic [7:0] m_frames;
    int         m_errs;
    logic [3:0] m_mode;
    bit         m_pending;
    bit         m_front_valid;

    function automatic void model_reset();
        pkt.delete();
        m_frames      = 8'd0;
        m_errs        = 0;
        m_mode        = 4'd0;
        m_pending     = 1'b0;
        m_front_valid = 1'b0;
    endfunction

    function automatic void model_err();
        if (m_errs < 255) m_errs = m_errs + 1;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] x;
        if (pkt.size() == 0) begin
            if (b == 8'hA5) pkt.push_back(b);
            return;
        end
        pkt.push_back(b);
        if (pkt.size() == 2) begin
            if (b == 8'h00) begin
                if (m_pending) begin
                    model_err();
                    pkt.delete();
                end
            end else begin
                if (b[7:4] == 4'h1) m_mode = b[3:0];
                else                model_err();
                pkt.delete();
            end
        end else if (pkt.size() == 67) begin
            x = 8'h00;
            for (int i = 1; i < 66; i++) x = x ^ pkt[i];
            if (x == b) begin
                m_pending = 1'b1;
                for (int i = 0; i < 64; i++) m_back[i] = pkt[i + 2];
            end else begin
                model_err();
            end
            pkt.delete();
        end
    endfunction

    function automatic void model_boundary();
        if (m_pending) begin
            m_front       = m_back;
            m_frames      = m_frames + 8'd1;
            m_front_valid = 1'b1;
            m_pending     = 1'b0;
        end
    endfunction

    function automatic void model_timeout();
        if (pkt.size() != 0) begin
            model_err();
            pkt.delete();
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [5:0] a);
        return m_front_valid ? m_front[a] : 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
        model_byte(b);
    endtask

    task automatic pulse_boundary();
        frame_boundary = 1'b1;
        @(negedge clk);
        frame_boundary = 1'b0;
        model_boundary();
    endtask

    task automatic send_frame(input logic [7:0] pl [64], input bit corrupt, input bit bnd_on_chk);
        logic [7:0] x;
        x = 8'h00;
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 64; i++) begin
            send_byte(pl[i]);
            x = x ^ pl[i];
        end
        if (corrupt) x = x ^ 8'h01;
        if (bnd_on_chk) begin
            frame_boundary = 1'b1;
            model_boundary();
        end
        send_byte(x);
        frame_boundary = 1'b0;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        byte_valid     = 1'b0;
        frame_boundary = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (mode !== 4'd0) begin errors++; $display("[TB] FAIL reset_mode got %0h want 0", mode); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_frame_count got %0d want 0", frame_count); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_err_count got %0d want 0", err_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_swap_pending got %b want 0", swap_pending); end
        rd_addr = 6'h2A;
        @(negedge clk);
        checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data got %h want 00", rd_data); end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] p [64];
        for (int i = 0; i < 64; i++) p[i] = 8'(i);
        send_frame(p, 1'b1, 1'b0);
        checks++; if (err_count !== 8'd1) begin errors++; $display("[TB] FAIL badchk_err got %0d want 1", err_count); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("[TB] FAIL badchk_pending got %b want 0", swap_pending); end
        pulse_boundary();
        rd_addr = 6'h2A;
        @(negedge clk);
        checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL badchk_rd_data got %h want 00", rd_data); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("[TB] FAIL badchk_frames got %0d want 0", frame_count); end
    endtask

    task automatic test_valid_frame();
        logic [7:0] p [64];
        logic [5:0] a;
        for (int i = 0; i < 64; i++) p[i] = 8'(i);
        send_frame(p, 1'b0, 1'b0);
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("[TB] FAIL valid_pending got %b want 1", swap_pending); end
        checks++; if (frame_count !== 8'd0) begin errors++; $display("[TB] FAIL valid_frames_pre got %0d want 0", frame_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL valid_busy got %b want 0", busy); end
        pulse_boundary();
        checks++; if (frame_count !== 8'd1) begin errors++; $display("[TB] FAIL valid_frames got %0d want 1", frame_count); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("[TB] FAIL valid_pending_clr got %b want 0", swap_pending); end
        rd_addr = 6'h2A;
        @(negedge clk);
        checks++; if (rd_data !== 8'h2A) begin errors++; $display("[TB] FAIL valid_rd_2a got %h want 2a", rd_data); end
        for (int k = 0; k < 4; k++) begin
            a = 6'($urandom);
            rd_addr = a;
            @(negedge clk);
            checks++; if (rd_data !== {2'b00, a}) begin errors++; $display("[TB] FAIL valid_rd addr %h got %h want %h", a, rd_data, {2'b00, a}); end
        end
    endtask

    task automatic test_mode();
        send_byte(8'hA5);
        send_byte(8'h13);
        checks++; if (mode !== 4'd3) begin errors++; $display("[TB] FAIL mode_set got %0h want 3", mode); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mode_busy got %b want 0", busy); end
        send_byte(8'hA5);
        send_byte(8'h27);
        checks++; if (mode !== 4'd3) begin errors++; $display("[TB] FAIL badcmd_mode got %0h want 3", mode); end
        checks++; if (err_count !== 8'd2) begin errors++; $display("[TB] FAIL badcmd_err got %0d want 2", err_count); end
    endtask

    task automatic test_timeout();
        logic [7:0] p [64];
        logic [5:0] a;
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom));
        repeat (T - 2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_busy_early got %b want 1", busy); end
        repeat (4) @(negedge clk);
        model_timeout();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy got %b want 0", busy); end
        checks++; if (err_count !== 8'd3) begin errors++; $display("[TB] FAIL timeout_err got %0d want 3", err_count); end
        for (int i = 0; i < 64; i++) p[i] = 8'($urandom);
        send_frame(p, 1'b0, 1'b0);
        pulse_boundary();
        checks++; if (frame_count !== 8'd2) begin errors++; $display("[TB] FAIL timeout_recover_frames got %0d want 2", frame_count); end
        for (int k = 0; k < 4; k++) begin
            a = 6'($urandom);
            rd_addr = a;
            @(negedge clk);
            checks++; if (rd_data !== p[a]) begin errors++; $display("[TB] FAIL timeout_recover_rd addr %h got %h want %h", a, rd_data, p[a]); end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] pa [64];
        logic [5:0] a;
        int         e0;
        for (int i = 0; i < 64; i++) pa[i] = 8'($urandom);
        send_frame(pa, 1'b0, 1'b0);
        e0 = m_errs;
        send_byte(8'hA5);
        send_byte(8'h00);
        for (int i = 0; i < 65; i++) send_byte(8'($urandom) & 8'h7F);
        checks++; if (err_count !== 8'(e0 + 1)) begin errors++; $display("[TB] FAIL overrun_err got %0d want %0d", err_count, e0 + 1); end
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("[TB] FAIL overrun_pending got %b want 1", swap_pending); end
        send_byte(8'hA5);
        send_byte(8'h12);
        checks++; if (mode !== 4'd2) begin errors++; $display("[TB] FAIL overrun_mode got %0h want 2", mode); end
        pulse_boundary();
        checks++; if (frame_count !== 8'd3) begin errors++; $display("[TB] FAIL overrun_frames got %0d want 3", frame_count); end
        for (int k = 0; k < 4; k++) begin
            a = 6'($urandom);
            rd_addr = a;
            @(negedge clk);
            checks++; if (rd_data !== pa[a]) begin errors++; $display("[TB] FAIL overrun_rd addr %h got %h want %h", a, rd_data, pa[a]); end
        end
    endtask

    task automatic test_same_cycle_boundary();
        logic [7:0] pb [64];
        logic [5:0] a;
        for (int i = 0; i < 64; i++) pb[i] = 8'($urandom);
        send_frame(pb, 1'b0, 1'b1);
        checks++; if (frame_count !== 8'd3) begin errors++; $display("[TB] FAIL samecyc_frames got %0d want 3", frame_count); end
        checks++; if (swap_pending !== 1'b1) begin errors++; $display("[TB] FAIL samecyc_pending got %b want 1", swap_pending); end
        pulse_boundary();
        checks++; if (frame_count !== 8'd4) begin errors++; $display("[TB] FAIL samecyc_frames_next got %0d want 4", frame_count); end
        a = 6'($urandom);
        rd_addr = a;
        @(negedge clk);
        checks++; if (rd_data !== pb[a]) begin errors++; $display("[TB] FAIL samecyc_rd addr %h got %h want %h", a, rd_data, pb[a]); end
    endtask

    task automatic test_random();
        logic [7:0] p [64];
        logic [7:0] g;
        logic [5:0] a;
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0, 1: begin
                    for (int i = 0; i < 64; i++) p[i] = 8'($urandom);
                    send_frame(p, 1'b0, $urandom_range(0, 3) == 0);
                end
                2: begin
                    for (int i = 0; i < 64; i++) p[i] = 8'($urandom);
                    send_frame(p, 1'b1, 1'b0);
                end
                3: begin
                    send_byte(8'hA5);
                    send_byte(8'($urandom));
                end
                4: begin
                    for (int i = 0; i < 3; i++) begin
                        g = 8'($urandom);
                        if (g == 8'hA5) g = 8'h5A;
                        send_byte(g);
                    end
                end
                default: pulse_boundary();
            endcase
            if ($urandom_range(0, 1) == 1) pulse_boundary();
            checks++; if (frame_count !== m_frames) begin errors++; $display("[TB] FAIL rand_frames it %0d got %0d want %0d", it, frame_count, m_frames); end
            checks++; if (err_count !== 8'(m_errs)) begin errors++; $display("[TB] FAIL rand_err it %0d got %0d want %0d", it, err_count, m_errs); end
            checks++; if (mode !== m_mode) begin errors++; $display("[TB] FAIL rand_mode it %0d got %0h want %0h", it, mode, m_mode); end
            checks++; if (swap_pending !== m_pending) begin errors++; $display("[TB] FAIL rand_pending it %0d got %b want %b", it, swap_pending, m_pending); end
            checks++; if (busy !== (pkt.size() != 0)) begin errors++; $display("[TB] FAIL rand_busy it %0d got %b want %b", it, busy, pkt.size() != 0); end
            a = 6'($urandom);
            rd_addr = a;
            @(negedge clk);
            checks++; if (rd_data !== model_read(a)) begin errors++; $display("[TB] FAIL rand_rd it %0d addr %h got %h want %h", it, a, rd_data, model_read(a)); end
        end
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 260; i++) begin
            send_byte(8'hA5);
            send_byte(8'h27);
        end
        checks++; if (err_count !== 8'd255) begin errors++; $display("[TB] FAIL err_saturate got %0d want 255", err_count); end
        checks++; if (err_count !== 8'(m_errs)) begin errors++; $display("[TB] FAIL err_saturate_model got %0d want %0d", err_count, m_errs); end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] p [64];
        pulse_boundary();
        for (int i = 0; i < 64; i++) p[i] = 8'($urandom);
        send_frame(p, 1'b0, 1'b0);
        send_byte(8'hA5);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midrst_busy_pre got %b want 1", busy); end
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", busy); end
        checks++; if (swap_pending !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pending got %b want 0", swap_pending); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("[TB] FAIL midrst_err got %0d want 0", err_count); end
        pulse_boundary();
        checks++; if (frame_count !== 8'd0) begin errors++; $display("[TB] FAIL midrst_frames got %0d want 0", frame_count); end
        rd_addr = 6'($urandom);
        @(negedge clk);
        checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL midrst_rd got %h want 00", rd_data); end
    endtask

    initial begin
        #600000;
        $display("[TB] FAIL watchdog expired checks %0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_bad_checksum();
        test_valid_frame();
        test_mode();
        test_timeout();
        test_overrun();
        test_same_cycle_boundary();
        test_random();
        test_err_saturation();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
